mux_sipo_capture: RTL and testbench
===================================

Name: mux_sipo_capture

Overview:
Downstream capture stage for the 2:1 multiplexer output. It samples the mux's 1-bit output Y serially under a valid strobe and assembles WIDTH bits MSB-first into a parallel word. It presents the word through a valid/ready handshake to the next datapath stage. It stalls the serial side while an unconsumed word is held, and counts bits dropped during the stall.

Parameters:
WIDTH, 4, number of serial bits per output word (legal range 2..16)
CNTW, 5, width of the internal bit counter; must satisfy 2^CNTW > WIDTH

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST  input  1  synchronous reset, active-high
DIN  input  1  serial data bit (driven by mux Y)
DIN_VALID  input  1  DIN carries a bit this cycle
DIN_READY  output  1  stage can accept a bit this cycle (combinational)
DOUT  output  WIDTH  assembled word, first-received bit in MSB
DOUT_VALID  output  1  DOUT holds a complete, unconsumed word
DOUT_READY  input  1  consumer accepts DOUT this cycle
BIT_CNT  output  CNTW  bits collected toward the current word (0..WIDTH-1)
DROP_CNT  output  8  number of DIN_VALID cycles refused, saturating

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RST), sampled on the CLK rising edge. It overrides all other inputs.
- Reset values: DOUT=0, DOUT_VALID=0, BIT_CNT=0, DROP_CNT=0, internal shift register=0, state=FILL. DIN_READY=1 after reset.
- States:
  - FILL: DOUT_VALID=0.
  - FULL: DOUT_VALID=1.
- DIN_READY = !DOUT_VALID || DOUT_READY. It is purely combinational, with no dependence on DIN_VALID.
- Bit accept = DIN_VALID && DIN_READY. On accept:
  - shreg <= {shreg[WIDTH-2:0], DIN}.
  - BIT_CNT <= BIT_CNT+1.
- Word completion: an accept with BIT_CNT==WIDTH-1 causes, on the next edge:
  - DOUT <= {shreg[WIDTH-2:0], DIN}.
  - DOUT_VALID <= 1, state FULL.
  - BIT_CNT <= 0.
- Latency: DOUT_VALID rises on the edge that samples the WIDTH-th bit, so it is visible in the cycle after that bit is presented.
- Drain: in FULL, DOUT_READY=1 at an edge means the word is consumed and DOUT_VALID <= 0 (state FILL). The exception is a simultaneous word completion, where DOUT_VALID stays 1 and DOUT reloads. DOUT keeps its last value after drain.
- Stall: in FULL with DOUT_READY=0, DIN_READY=0. Incoming bits are discarded, and shreg, BIT_CNT and DOUT are held.
- Drop counting: each edge with DIN_VALID=1 && DIN_READY=0 increments DROP_CNT. It saturates at 255 and never wraps. It is cleared only by RST.
- Simultaneous drain + bit: the bit is accepted into the new word in the same cycle, with no bubble.
- DIN_VALID=0 cycles leave shreg and BIT_CNT unchanged. Gaps between bits are allowed.
- Reset mid-word: partial bits are lost and the next accepted bit starts a fresh word at BIT_CNT=0.
- No X propagation: DOUT changes only on word completion or reset.

Test Plan:
1. Reset: RST=1 for 2 cycles with DIN_VALID=1, DIN=1 -> DOUT=0, DOUT_VALID=0, BIT_CNT=0, DROP_CNT=0, DIN_READY=1.
2. Basic word: DOUT_READY=1, bits 1,0,1,1 on 4 consecutive cycles -> next cycle DOUT=4'b1011, DOUT_VALID=1 for exactly 1 cycle, BIT_CNT=0.
3. Gapped input: bits 0,1,1,0 with idle cycles between each -> BIT_CNT steps 1,2,3 and holds during gaps; DOUT=4'b0110 after the 4th bit.
4. Backpressure: DOUT_READY=0, complete word 4'b1100, then 3 more DIN_VALID cycles -> DIN_READY=0, DOUT stays 1100, DROP_CNT=3, BIT_CNT=0. Then DOUT_READY=1 for 1 cycle -> DOUT_VALID=0 next cycle.
5. Simultaneous drain + input: DOUT_VALID=1 and DOUT_READY=1 while DIN_VALID=1, DIN=1 -> bit accepted, BIT_CNT=1 next cycle, DOUT_VALID=0.
6. Reset mid-word and drop saturation:
   - 2 bits in, then RST 1 cycle, then 1,1,1,0 -> DOUT=4'b1110.
   - Separately, 300 stalled DIN_VALID cycles -> DROP_CNT=255.

Source files
------------

// File: rtl/mux_sipo_capture.sv
// mux_sipo_capture: serial-to-parallel capture stage for the 2:1 mux output.
// Shifts DIN in MSB-first under DIN_VALID and assembles WIDTH-bit words.
// Each word is presented on DOUT through a DOUT_VALID/DOUT_READY handshake.
// While an unconsumed word is held the serial side stalls, and every refused
// bit is counted in a saturating drop counter.
//
// Ports:
//   CLK         system clock, rising edge
//   RST         synchronous reset, active-high
//   DIN         serial data bit
//   DIN_VALID   DIN carries a bit this cycle
//   DIN_READY   stage can take a bit this cycle (combinational)
//   DOUT        assembled word, first-received bit in MSB
//   DOUT_VALID  DOUT holds a complete, unconsumed word
//   DOUT_READY  consumer takes DOUT this cycle
//   BIT_CNT     bits collected toward the current word
//   DROP_CNT    refused DIN_VALID cycles, saturating at 255
module mux_sipo_capture #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNTW  = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic [WIDTH-1:0] DOUT,
  output logic             DOUT_VALID,
  input  logic             DOUT_READY,
  output logic [CNTW-1:0]  BIT_CNT,
  output logic [7:0]       DROP_CNT
);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  localparam int unsigned DROPW = 8;
  localparam logic [CNTW-1:0]  LAST_BIT = CNTW'(WIDTH - 1);
  localparam logic [DROPW-1:0] DROP_MAX = '1;

  logic [0:0]       state, state_n;
  // Only WIDTH-1 bits of history are needed: the newest bit comes from DIN.
  logic [WIDTH-2:0] shreg, shreg_n;
  logic [WIDTH-1:0] dout_n;
  logic [WIDTH-1:0] word_n;
  logic [CNTW-1:0]  bit_cnt_n;
  logic [DROPW-1:0] drop_cnt_n;
  logic             accept;
  logic             complete;

  // Ready whenever no word is held or the held word drains this cycle.
  assign DIN_READY  = (state == FILL) || DOUT_READY;
  assign DOUT_VALID = (state == FULL);

  // State register and datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= FILL;
      shreg    <= '0;
      DOUT     <= '0;
      BIT_CNT  <= '0;
      DROP_CNT <= '0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      DOUT     <= dout_n;
      BIT_CNT  <= bit_cnt_n;
      DROP_CNT <= drop_cnt_n;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    dout_n     = DOUT;
    bit_cnt_n  = BIT_CNT;
    drop_cnt_n = DROP_CNT;

    accept   = DIN_VALID && DIN_READY;
    complete = accept && (BIT_CNT == LAST_BIT);
    word_n   = {shreg, DIN};

    if (accept) begin
      shreg_n   = word_n[WIDTH-2:0];
      bit_cnt_n = complete ? '0 : BIT_CNT + CNTW'(1);
    end

    if (DIN_VALID && !DIN_READY && (DROP_CNT != DROP_MAX)) begin
      drop_cnt_n = DROP_CNT + DROPW'(1);
    end

    // A completion in the same cycle as a drain keeps the stage FULL.
    case (state)
      FILL: begin
        if (complete) begin
          state_n = FULL;
          dout_n  = word_n;
        end
      end
      FULL: begin
        if (complete) begin
          state_n = FULL;
          dout_n  = word_n;
        end else if (DOUT_READY) begin
          state_n = FILL;
        end
      end
      default: state_n = FILL;
    endcase
  end

endmodule

// File: tb/tb_mux_sipo_capture.sv
// Testbench for mux_sipo_capture: directed scenarios followed by random
// traffic, checked every cycle against a queue-based reference model.
module tb_mux_sipo_capture;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNTW  = 5;

  logic             CLK;
  logic             RST;
  logic             DIN;
  logic             DIN_VALID;
  logic             DIN_READY;
  logic [WIDTH-1:0] DOUT;
  logic             DOUT_VALID;
  logic             DOUT_READY;
  logic [CNTW-1:0]  BIT_CNT;
  logic [7:0]       DROP_CNT;

  mux_sipo_capture #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .DIN        (DIN),
    .DIN_VALID  (DIN_VALID),
    .DIN_READY  (DIN_READY),
    .DOUT       (DOUT),
    .DOUT_VALID (DOUT_VALID),
    .DOUT_READY (DOUT_READY),
    .BIT_CNT    (BIT_CNT),
    .DROP_CNT   (DROP_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: partial word as a bit queue, held word, valid flag, drops.
  bit m_known = 0;
  int m_bits[$];
  int m_word  = 0;
  bit m_valid = 0;
  int m_drops = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update(input bit rst, input bit dv, input bit d, input bit dr);
    bit ready;
    bit drained;
    bit completed;
    int w;
    if (rst) begin
      m_bits.delete();
      m_word  = 0;
      m_valid = 0;
      m_drops = 0;
      m_known = 1;
    end else begin
      ready     = !m_valid || dr;
      drained   = m_valid && dr;
      completed = 0;
      if (dv && !ready && m_drops < 255) m_drops = m_drops + 1;
      if (dv && ready) begin
        m_bits.push_back(int'(d));
        if (m_bits.size() == WIDTH) begin
          w = 0;
          foreach (m_bits[i]) w = (w << 1) | m_bits[i];
          m_word = w;
          m_bits.delete();
          completed = 1;
        end
      end
      if (completed) m_valid = 1;
      else if (drained) m_valid = 0;
    end
  endtask

  // Drive one cycle: check outputs mid-cycle, then advance model at the edge.
  task automatic cycle(input bit rst, input bit dv, input bit d, input bit dr);
    RST        = rst;
    DIN_VALID  = dv;
    DIN        = d;
    DOUT_READY = dr;
    @(negedge CLK);
    if (m_known) begin
      check("din_ready",  32'(DIN_READY),  32'(!m_valid || dr));
      check("dout",       32'(DOUT),       32'(m_word));
      check("dout_valid", 32'(DOUT_VALID), 32'(m_valid));
      check("bit_cnt",    32'(BIT_CNT),    32'(m_bits.size()));
      check("drop_cnt",   32'(DROP_CNT),   32'(m_drops));
    end
    @(posedge CLK);
    model_update(rst, dv, d, dr);
    #1;
  endtask

  initial begin
    bit [3:0] pat;
    RST = 1'b0; DIN = 1'b0; DIN_VALID = 1'b0; DOUT_READY = 1'b0;

    // Reset held two cycles with a bit offered.
    cycle(1, 1, 1, 0);
    cycle(1, 1, 1, 0);
    check("rst_dout",      32'(DOUT),       32'h0);
    check("rst_dout_vld",  32'(DOUT_VALID), 32'h0);
    check("rst_bit_cnt",   32'(BIT_CNT),    32'h0);
    check("rst_drop_cnt",  32'(DROP_CNT),   32'h0);
    check("rst_din_ready", 32'(DIN_READY),  32'h1);

    // Basic word 1011 with consumer always ready.
    pat = 4'b1011;
    for (int i = 3; i >= 0; i--) cycle(0, 1, pat[i], 1);
    check("basic_dout",    32'(DOUT),       32'hB);
    check("basic_valid",   32'(DOUT_VALID), 32'h1);
    check("basic_bit_cnt", 32'(BIT_CNT),    32'h0);
    cycle(0, 0, 0, 1);
    check("basic_valid_1cyc", 32'(DOUT_VALID), 32'h0);

    // Gapped word 0110.
    pat = 4'b0110;
    for (int i = 3; i >= 0; i--) begin
      cycle(0, 1, pat[i], 1);
      if (i > 0) check("gap_bit_cnt", 32'(BIT_CNT), 32'(4 - i));
      cycle(0, 0, 1, 1);
      if (i > 0) check("gap_bit_hold", 32'(BIT_CNT), 32'(4 - i));
    end
    check("gap_dout", 32'(DOUT), 32'h6);

    // Backpressure: word 1100, then three refused bits.
    pat = 4'b1100;
    for (int i = 3; i >= 0; i--) cycle(0, 1, pat[i], 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0);
    check("bp_din_ready", 32'(DIN_READY), 32'h0);
    check("bp_dout",      32'(DOUT),      32'hC);
    check("bp_drop_cnt",  32'(DROP_CNT),  32'h3);
    check("bp_bit_cnt",   32'(BIT_CNT),   32'h0);
    cycle(0, 0, 0, 1);
    check("bp_drain", 32'(DOUT_VALID), 32'h0);

    // Drain and accept a bit in the same cycle.
    pat = 4'b0101;
    for (int i = 3; i >= 0; i--) cycle(0, 1, pat[i], 0);
    cycle(0, 1, 1, 1);
    check("sim_bit_cnt", 32'(BIT_CNT),    32'h1);
    check("sim_valid",   32'(DOUT_VALID), 32'h0);

    // Reset mid-word, then a fresh word 1110.
    cycle(0, 1, 0, 1);
    cycle(1, 0, 0, 1);
    check("midrst_bit_cnt", 32'(BIT_CNT), 32'h0);
    pat = 4'b1110;
    for (int i = 3; i >= 0; i--) cycle(0, 1, pat[i], 0);
    check("midrst_dout", 32'(DOUT), 32'hE);

    // Drop counter saturation.
    for (int i = 0; i < 300; i++) cycle(0, 1, i[0], 0);
    check("drop_sat", 32'(DROP_CNT), 32'd255);

    // Random traffic.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 127) == 0), ($urandom_range(0, 3) != 0),
            $urandom_range(0, 1) == 1, ($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
